// File: rtl/nanomamba_kw_decision_if.sv
// ---------------------------------------------------------------------------
// nanomamba_kw_decision_if
// Groups the two handshake buses of the keyword decision block:
//   - s_axis_logit_* : AXI4-Stream result input, N_CLASSES packed INT8 logits
//                      (class k at [k*8 +: 8]); tlast is carried but unused.
//   - det_*          : valid/ready detection report towards the host.
// Modports:
//   master : host / result-producer side (drives stream and det_ready)
//   slave  : the decision block
// ---------------------------------------------------------------------------
interface nanomamba_kw_decision_if #(
    parameter int N_CLASSES = 12
);
    logic [N_CLASSES*8-1:0] s_axis_logit_tdata;
    logic                   s_axis_logit_tvalid;
    logic                   s_axis_logit_tready;
    logic                   s_axis_logit_tlast;
    logic                   det_valid;
    logic                   det_ready;
    logic [3:0]             det_class;
    logic [7:0]             det_score;

    modport master (
        output s_axis_logit_tdata, s_axis_logit_tvalid, s_axis_logit_tlast, det_ready,
        input  s_axis_logit_tready, det_valid, det_class, det_score
    );

    modport slave (
        input  s_axis_logit_tdata, s_axis_logit_tvalid, s_axis_logit_tlast, det_ready,
        output s_axis_logit_tready, det_valid, det_class, det_score
    );
endinterface

// File: rtl/nanomamba_kw_decision.sv
// ---------------------------------------------------------------------------
// nanomamba_kw_decision
// Consumes 12 x INT8 logit results, keeps a sliding window of the last
// 2^LOG2_WIN results as per-class running sums, scans the window averages for
// the best class and reports a keyword detection (valid/ready + irq pulse)
// when it clears the threshold, is not silence/unknown and the refractory
// counter allows it.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     logit stream in, detection report out
//   cfg_threshold   signed threshold on the averaged logit (sampled in DECIDE)
//   cfg_refract     results suppressed after a detection (sampled in DECIDE)
//   cfg_clear       synchronous clear of window, counters and pending report
//   irq_detect      one-cycle pulse when det_valid rises
//   busy            high whenever the FSM is not idle
// Optional feature: define KW_DECISION_HYST_EN to add per-class re-arm
// hysteresis (a class must fall to threshold - HYST_MARGIN before it can be
// reported again).
// ---------------------------------------------------------------------------
module nanomamba_kw_decision #(
    parameter int N_CLASSES     = 12,
    parameter int LOG2_WIN      = 2,
    parameter int SILENCE_CLASS = 0,
    parameter int UNKNOWN_CLASS = 1,
    parameter int HYST_MARGIN   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nanomamba_kw_decision_if.slave bus,
    input  logic signed [7:0]      cfg_threshold,
    input  logic [7:0]             cfg_refract,
    input  logic                   cfg_clear,
    output logic                   irq_detect,
    output logic                   busy
);
    localparam int WIN_LEN = 1 << LOG2_WIN;
    localparam int SW      = 8 + LOG2_WIN;
    localparam int IW      = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam int FW      = LOG2_WIN + 1;
    localparam int HW      = (SW > 10) ? SW : 10;

    typedef enum logic [2:0] {IDLE, UPDATE, SCAN, DECIDE, REPORT} state_e;

    // Sign-extend one INT8 logit to running-sum width.
    function automatic logic signed [SW-1:0] sext8(input logic [7:0] v);
        return SW'($signed(v));
    endfunction

    state_e                              state_q, state_d;
    logic [N_CLASSES*8-1:0]              new_q, new_d;
    logic [WIN_LEN-1:0][N_CLASSES*8-1:0] ring_q, ring_d;
    logic signed [SW-1:0]                sum_q [N_CLASSES];
    logic signed [SW-1:0]                sum_d [N_CLASSES];
    logic [LOG2_WIN-1:0]                 wptr_q, wptr_d;
    logic [FW-1:0]                       fill_q, fill_d;
    logic [7:0]                          refract_q, refract_d;
    logic                                block_q, block_d;
    logic [IW-1:0]                       idx_q, idx_d;
    logic [IW-1:0]                       best_class_q, best_class_d;
    logic signed [SW-1:0]                best_avg_q, best_avg_d;
    logic                                det_valid_q, det_valid_d;
    logic [3:0]                          det_class_q, det_class_d;
    logic [7:0]                          det_score_q, det_score_d;
    logic                                irq_q, irq_d;
    logic                                tready_q, tready_d;
    logic                                busy_q, busy_d;

    logic signed [SW-1:0]                avg_s;
    logic signed [SW-1:0]                thr_s;
    logic                                detect_s;
    logic                                unused_tlast_s;

`ifdef KW_DECISION_HYST_EN
    logic [N_CLASSES-1:0]                armed_q, armed_d;
    logic signed [HW-1:0]                thr_lo_s;
    logic signed [HW-1:0]                avg_h_s;
`else
    logic [HW-1:0]                       unused_hyst_s;
    assign unused_hyst_s = HW'(HYST_MARGIN);
`endif

    assign unused_tlast_s          = bus.s_axis_logit_tlast;
    assign bus.s_axis_logit_tready = tready_q;
    assign bus.det_valid           = det_valid_q;
    assign bus.det_class           = det_class_q;
    assign bus.det_score           = det_score_q;
    assign irq_detect              = irq_q;
    assign busy                    = busy_q;

    // Next-state logic for the FSM, window storage and report registers.
    always_comb begin
        state_d      = state_q;
        new_d        = new_q;
        ring_d       = ring_q;
        sum_d        = sum_q;
        wptr_d       = wptr_q;
        fill_d       = fill_q;
        refract_d    = refract_q;
        block_d      = block_q;
        idx_d        = idx_q;
        best_class_d = best_class_q;
        best_avg_d   = best_avg_q;
        det_valid_d  = det_valid_q;
        det_class_d  = det_class_q;
        det_score_d  = det_score_q;
        irq_d        = 1'b0;
        avg_s        = sum_q[idx_q] >>> LOG2_WIN;
        thr_s        = SW'(cfg_threshold);
`ifdef KW_DECISION_HYST_EN
        armed_d      = armed_q;
        thr_lo_s     = HW'(cfg_threshold) - HW'(HYST_MARGIN);
        avg_h_s      = HW'(avg_s);
`endif
        detect_s = (fill_q == FW'(WIN_LEN))
                 & (best_class_q != IW'(SILENCE_CLASS))
                 & (best_class_q != IW'(UNKNOWN_CLASS))
                 & (best_avg_q > thr_s)
                 & ~block_q;
`ifdef KW_DECISION_HYST_EN
        detect_s = detect_s & armed_q[best_class_q];
`endif

        case (state_q)
            IDLE: begin
                if (bus.s_axis_logit_tvalid && tready_q) begin
                    new_d   = bus.s_axis_logit_tdata;
                    state_d = UPDATE;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                for (int k = 0; k < N_CLASSES; k++) begin
                    sum_d[k] = sum_q[k] + sext8(new_q[k*8 +: 8])
                             - sext8(ring_q[wptr_q][k*8 +: 8]);
                end
                ring_d[wptr_q] = new_q;
                wptr_d         = wptr_q + LOG2_WIN'(1);
                if (fill_q != FW'(WIN_LEN)) begin
                    fill_d = fill_q + FW'(1);
                end else begin
                    fill_d = fill_q;
                end
                // Gate on the count seen by this result before it ticks down,
                // so cfg_refract = N suppresses exactly the next N results.
                block_d = (refract_q != 8'd0);
                if (refract_q != 8'd0) begin
                    refract_d = refract_q - 8'd1;
                end else begin
                    refract_d = refract_q;
                end
                idx_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                // Strict '>' keeps the lowest index on ties.
                if ((idx_q == '0) || (avg_s > best_avg_q)) begin
                    best_class_d = idx_q;
                    best_avg_d   = avg_s;
                end else begin
                    best_avg_d   = best_avg_q;
                end
`ifdef KW_DECISION_HYST_EN
                if (avg_h_s <= thr_lo_s) begin
                    armed_d[idx_q] = 1'b1;
                end else begin
                    armed_d[idx_q] = armed_q[idx_q];
                end
`endif
                if (idx_q == IW'(N_CLASSES - 1)) begin
                    state_d = DECIDE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                end
            end
            DECIDE: begin
                if (detect_s) begin
                    det_valid_d = 1'b1;
                    irq_d       = 1'b1;
                    det_class_d = 4'(best_class_q);
                    det_score_d = best_avg_q[7:0];
                    refract_d   = cfg_refract;
`ifdef KW_DECISION_HYST_EN
                    armed_d[best_class_q] = 1'b0;
`endif
                    state_d     = REPORT;
                end else begin
                    state_d     = IDLE;
                end
            end
            REPORT: begin
                if (bus.det_ready) begin
                    det_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = REPORT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear overrides everything, including an in-flight handshake.
        if (cfg_clear) begin
            state_d     = IDLE;
            det_valid_d = 1'b0;
            irq_d       = 1'b0;
            ring_d      = '0;
            wptr_d      = '0;
            fill_d      = '0;
            refract_d   = 8'd0;
            block_d     = 1'b0;
            for (int k = 0; k < N_CLASSES; k++) begin
                sum_d[k] = '0;
            end
`ifdef KW_DECISION_HYST_EN
            armed_d     = '1;
`endif
        end else begin
            state_d     = state_d;
        end

        tready_d = (state_d == IDLE);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            new_q        <= '0;
            ring_q       <= '0;
            for (int k = 0; k < N_CLASSES; k++) begin
                sum_q[k] <= '0;
            end
            wptr_q       <= '0;
            fill_q       <= '0;
            refract_q    <= 8'd0;
            block_q      <= 1'b0;
            idx_q        <= '0;
            best_class_q <= '0;
            best_avg_q   <= '0;
            det_valid_q  <= 1'b0;
            det_class_q  <= 4'd0;
            det_score_q  <= 8'd0;
            irq_q        <= 1'b0;
            tready_q     <= 1'b1;
            busy_q       <= 1'b0;
`ifdef KW_DECISION_HYST_EN
            armed_q      <= '1;
`endif
        end else begin
            state_q      <= state_d;
            new_q        <= new_d;
            ring_q       <= ring_d;
            sum_q        <= sum_d;
            wptr_q       <= wptr_d;
            fill_q       <= fill_d;
            refract_q    <= refract_d;
            block_q      <= block_d;
            idx_q        <= idx_d;
            best_class_q <= best_class_d;
            best_avg_q   <= best_avg_d;
            det_valid_q  <= det_valid_d;
            det_class_q  <= det_class_d;
            det_score_q  <= det_score_d;
            irq_q        <= irq_d;
            tready_q     <= tready_d;
            busy_q       <= busy_d;
`ifdef KW_DECISION_HYST_EN
            armed_q      <= armed_d;
`endif
        end
    end
endmodule

// File: tb/tb_nanomamba_kw_decision.sv
// ---------------------------------------------------------------------------
// tb_nanomamba_kw_decision
// Directed bench for nanomamba_kw_decision with hand-computed expectations:
// reset state, warm-up gating and latency, averaging/threshold, tie-break,
// silence rejection, refractory, backpressure, clear in REPORT and an
// asynchronous reset during SCAN.
// ---------------------------------------------------------------------------
module tb_nanomamba_kw_decision;
    logic              clk;
    logic              rst_n;
    logic signed [7:0] cfg_threshold;
    logic [7:0]        cfg_refract;
    logic              cfg_clear;
    logic              irq_detect;
    logic              busy;
    int                checks;
    int                errors;
    logic              det;
    int                lat;
    logic [95:0]       d;
    logic              stable;

    nanomamba_kw_decision_if #(.N_CLASSES(12)) bus ();

    nanomamba_kw_decision dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .cfg_threshold (cfg_threshold),
        .cfg_refract   (cfg_refract),
        .cfg_clear     (cfg_clear),
        .irq_detect    (irq_detect),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input int other, input int c1, input int v1,
                                        input int c2, input int v2);
        logic [95:0] r;
        for (int k = 0; k < 12; k++) r[k*8 +: 8] = 8'(other);
        r[c1*8 +: 8] = 8'(v1);
        r[c2*8 +: 8] = 8'(v2);
        return r;
    endfunction

    // Called at a negedge while idle; returns at the first negedge where
    // det_valid is high (det=1) or the block is idle again (det=0).
    task automatic send_result(input logic [95:0] data, output logic got, output int cyc);
        got = 1'b0;
        cyc = 0;
        bus.s_axis_logit_tdata  = data;
        bus.s_axis_logit_tvalid = 1'b1;
        @(negedge clk);
        bus.s_axis_logit_tvalid = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.det_valid === 1'b1) begin
                got = 1'b1;
                cyc = i;
                break;
            end
            if (bus.s_axis_logit_tready === 1'b1) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic expect_result(input string tag, input logic [95:0] data, input logic exp_det);
        logic g;
        int   c;
        send_result(data, g, c);
        if (c == 0) check({tag, "_timeout"}, 32'(c), 32'd15);
        else        check(tag, 32'(g), 32'(exp_det));
    endtask

    task automatic ack(input string tag);
        bus.det_ready = 1'b1;
        @(negedge clk);
        bus.det_ready = 1'b0;
        check({tag, "_ack_tready"}, 32'(bus.s_axis_logit_tready), 32'd1);
        check({tag, "_ack_valid"},  32'(bus.det_valid), 32'd0);
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        cfg_threshold = 8'sd20;
        cfg_refract = 8'd0;
        cfg_clear = 1'b0;
        bus.s_axis_logit_tdata = '0;
        bus.s_axis_logit_tvalid = 1'b0;
        bus.s_axis_logit_tlast = 1'b1;
        bus.det_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_tready", 32'(bus.s_axis_logit_tready), 32'd1);
        check("rst_valid",  32'(bus.det_valid), 32'd0);
        check("rst_irq",    32'(irq_detect), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_class",  32'(bus.det_class), 32'd0);
        check("rst_score",  32'(bus.det_score), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Warm-up: class 5 = 60, rest -10; detection only on the 4th result
        d = mk(-10, 5, 60, 5, 60);
        expect_result("warm_r1", d, 1'b0);
        expect_result("warm_r2", d, 1'b0);
        expect_result("warm_r3", d, 1'b0);
        send_result(d, det, lat);
        check("warm_r4_det",   32'(det), 32'd1);
        check("warm_r4_lat",   32'(lat), 32'd15);
        check("warm_r4_class", 32'(bus.det_class), 32'd5);
        check("warm_r4_score", 32'(bus.det_score), 32'd60);
        check("warm_r4_irq",   32'(irq_detect), 32'd1);
        check("warm_r4_busy",  32'(busy), 32'd1);
        @(negedge clk);
        check("warm_irq_once", 32'(irq_detect), 32'd0);
        check("warm_hold",     32'(bus.det_valid), 32'd1);
        ack("warm");

        // Averaging: class 3 window {40,40,0,0} averages 20
        pulse_clear();
        expect_result("avg20_r1", mk(-10, 3, 40, 3, 40), 1'b0);
        expect_result("avg20_r2", mk(-10, 3, 40, 3, 40), 1'b0);
        expect_result("avg20_r3", mk(-10, 3, 0, 3, 0), 1'b0);
        expect_result("avg20_thr20", mk(-10, 3, 0, 3, 0), 1'b0);
        pulse_clear();
        cfg_threshold = 8'sd19;
        expect_result("avg19_r1", mk(-10, 3, 40, 3, 40), 1'b0);
        expect_result("avg19_r2", mk(-10, 3, 40, 3, 40), 1'b0);
        expect_result("avg19_r3", mk(-10, 3, 0, 3, 0), 1'b0);
        expect_result("avg19_thr19", mk(-10, 3, 0, 3, 0), 1'b1);
        check("avg19_class", 32'(bus.det_class), 32'd3);
        check("avg19_score", 32'(bus.det_score), 32'd20);
        ack("avg19");

        // Tie between classes 2 and 7 resolves to 2
        pulse_clear();
        cfg_threshold = 8'sd20;
        d = mk(-10, 2, 50, 7, 50);
        repeat (3) expect_result("tie_warm", d, 1'b0);
        expect_result("tie_det", d, 1'b1);
        check("tie_class", 32'(bus.det_class), 32'd2);
        check("tie_score", 32'(bus.det_score), 32'd50);
        ack("tie");

        // Silence class wins the argmax: never reported
        pulse_clear();
        d = mk(-10, 0, 100, 5, 50);
        repeat (4) expect_result("silence", d, 1'b0);

        // Refractory: 3 results suppressed after each detection
        pulse_clear();
        cfg_refract = 8'd3;
        d = mk(-10, 4, 60, 4, 60);
        repeat (3) expect_result("refr_warm", d, 1'b0);
        expect_result("refr_r4", d, 1'b1);
        check("refr_r4_class", 32'(bus.det_class), 32'd4);
        ack("refr_r4");
        expect_result("refr_r5", d, 1'b0);
        expect_result("refr_r6", d, 1'b0);
        expect_result("refr_r7", d, 1'b0);
`ifdef KW_DECISION_HYST_EN
        expect_result("refr_r8", d, 1'b0);
`else
        expect_result("refr_r8", d, 1'b1);
        ack("refr_r8");
`endif
        cfg_refract = 8'd0;

        // Backpressure: hold det_ready low for 50 cycles
        pulse_clear();
        d = mk(-10, 5, 60, 5, 60);
        repeat (3) expect_result("bp_warm", d, 1'b0);
        expect_result("bp_det", d, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.det_valid !== 1'b1 || bus.det_class !== 4'd5 ||
                bus.det_score !== 8'd60 || bus.s_axis_logit_tready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        ack("bp");

        // cfg_clear during REPORT drops the report and empties the window
        pulse_clear();
        repeat (3) expect_result("clr_warm", d, 1'b0);
        expect_result("clr_det", d, 1'b1);
        pulse_clear();
        check("clr_valid",  32'(bus.det_valid), 32'd0);
        check("clr_tready", 32'(bus.s_axis_logit_tready), 32'd1);
        check("clr_busy",   32'(busy), 32'd0);
        expect_result("clr_r1", d, 1'b0);
        expect_result("clr_r2", d, 1'b0);
        expect_result("clr_r3", d, 1'b0);
        expect_result("clr_r4", d, 1'b1);
        check("clr_r4_class", 32'(bus.det_class), 32'd5);
        ack("clr");

        // Asynchronous reset during SCAN
        bus.s_axis_logit_tdata  = d;
        bus.s_axis_logit_tvalid = 1'b1;
        @(negedge clk);
        bus.s_axis_logit_tvalid = 1'b0;
        repeat (4) @(negedge clk);
        check("scan_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_tready", 32'(bus.s_axis_logit_tready), 32'd1);
        check("arst_busy",   32'(busy), 32'd0);
        check("arst_valid",  32'(bus.det_valid), 32'd0);
        check("arst_irq",    32'(irq_detect), 32'd0);
        check("arst_class",  32'(bus.det_class), 32'd0);
        check("arst_score",  32'(bus.det_score), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // After reset the window is empty again: one strong result, no detection
        expect_result("post_rst", d, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
